cas_sdram_arb: RTL
==================

Name: cas_sdram_arb

Overview:
- Shares the single SDRAM read port between the cassette player's byte fetch (port 0) and a second byte reader (port 1), e.g. a ROM/loader fetch.
- Each requester issues a one-cycle read pulse with an address. The arbiter grants requests round-robin, runs one SDRAM read at a time, then returns the byte with a one-cycle acknowledge.
- Sits between the cassette/loader logic and the SDRAM controller's byte read interface.

Parameters:
- ADDR_W, 25, SDRAM byte address width.
- DATA_W, 8, data width.
- RD_LAT, 2, cycles from the sdram_rd high cycle to valid sdram_data (minimum 1).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req0  in  1  port 0 (cassette) read request, single-cycle pulse
- addr0  in  ADDR_W  port 0 address, valid while req0 is high
- flush0  in  1  port 0 abort (cassette rewind/stop), single-cycle pulse
- ack0  out  1  port 0 data valid, single-cycle pulse
- data0  out  DATA_W  port 0 read byte, held until next ack0
- req1  in  1  port 1 read request pulse
- addr1  in  ADDR_W  port 1 address
- ack1  out  1  port 1 data valid pulse
- data1  out  DATA_W  port 1 read byte, held until next ack1
- sdram_addr  out  ADDR_W  SDRAM read address
- sdram_rd  out  1  SDRAM read strobe, exactly one cycle per read
- sdram_data  in  DATA_W  SDRAM read data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (reset_n low, async): all outputs 0; state IDLE; pend0 = pend1 = 0; last_grant = 1, so port 0 wins the first tie.
- Request capture:
  - reqN high at a clock edge sets pendN and latches addrN into a per-port address register.
  - reqN while pendN is already set, or while port N is in flight, is ignored; the first request stands.
  - Set dominates clear: a reqN pulse in the same cycle pendN is cleared by a grant re-sets pendN.
- State machine:
  - IDLE: if no pending request, stay in IDLE. Otherwise select a port:
    - only one pending: grant it;
    - both pending: grant the port != last_grant.
  - On the grant edge: clear that port's pend, set gnt, last_grant <= gnt, sdram_addr <= latched address, sdram_rd <= 1, go to ISSUE.
  - ISSUE (one cycle, sdram_rd high): sdram_rd <= 0, cnt <= RD_LAT-1, go to WAIT.
  - WAIT: if cnt != 0, decrement cnt. If cnt == 0:
    - dataGNT <= sdram_data;
    - ackGNT <= 1, unless the port is killed (see flush0);
    - go to IDLE.
- Latency: req pulse in cycle 0 -> grant edge ends cycle 1 -> sdram_rd high cycle 2 -> data sampled at end of cycle 2+RD_LAT -> ack high in cycle 3+RD_LAT (cycle 5 with default RD_LAT).
- Back-to-back: the ack cycle coincides with IDLE, so the next grant's sdram_rd rises one cycle after ack. Minimum read spacing is RD_LAT+2 cycles.
- Other output rules:
  - ackN is high only in the single cycle after capture.
  - dataN changes only on capture for port N; the other port's data is untouched.
  - sdram_addr holds its last value when idle.
- flush0:
  - clears pend0;
  - if port 0 is in flight (ISSUE/WAIT with gnt = 0), sets kill0. The read completes on SDRAM, but data0 and ack0 are not updated.
  - kill0 clears on returning to IDLE.
  - flush0 has no effect on port 1.
  - If flush0 and req0 arrive in the same cycle, the request wins: pend0 is set with the new address.
- Fairness: under continuous requests from both ports, grants strictly alternate 0,1,0,1…
- Reset mid-transaction: immediate return to reset values, with no ack for the in-flight read.

Test Plan:
1. Single read: req0 with addr0=0x000010, SDRAM model returns 0xA5 at RD_LAT=2 -> one sdram_rd pulse with sdram_addr=0x000010; ack0 exactly 5 cycles after req0; data0=0xA5; ack1 stays 0.
2. Simultaneous first request: req0 (addr 0x100) and req1 (addr 0x200) in the same cycle after reset -> port 0 is served first, then port 1. Exactly two sdram_rd pulses, 4 cycles apart; ack0 precedes ack1 by 4 cycles.
3. Fairness: both ports re-request on every ack for 20 transactions -> grant order alternates strictly; no sdram_rd pulse ever exceeds one cycle; busy drops only in ack cycles.
4. Flush mid-read: req0, then flush0 during WAIT -> sdram_rd still issued once; ack0 never asserts; data0 unchanged; a subsequent req1 is served normally.
5. Duplicate/ignored requests and same-cycle set/clear:
   - req0 twice while pend0 is set -> exactly one read, at the first address;
   - req1 in the cycle port 1 is granted -> a second port-1 read follows.
6. Async reset at WAIT cnt=1 -> all outputs 0 immediately; no ack; after reset release, a req1 completes with ack1 at +5 cycles.

Source files
------------

// File: rtl/cas_sdram_arb_if.sv
// Bus bundle between the cassette/loader byte requesters, the read arbiter
// and the SDRAM controller's byte read port.
interface cas_sdram_arb_if #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned DATA_W = 8
) ();
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              flush0;
    logic              ack0;
    logic [DATA_W-1:0] data0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              ack1;
    logic [DATA_W-1:0] data1;
    logic [ADDR_W-1:0] sdram_addr;
    logic              sdram_rd;
    logic [DATA_W-1:0] sdram_data;
    logic              busy;

    // Arbiter side
    modport slave (
        input  req0, addr0, flush0, req1, addr1, sdram_data,
        output ack0, data0, ack1, data1, sdram_addr, sdram_rd, busy
    );

    // Requester / SDRAM side
    modport master (
        output req0, addr0, flush0, req1, addr1, sdram_data,
        input  ack0, data0, ack1, data1, sdram_addr, sdram_rd, busy
    );
endinterface

// File: rtl/cas_sdram_arb.sv
// Round-robin arbiter sharing the SDRAM byte read port between the cassette
// fetch (port 0, abortable via flush0) and a second byte reader (port 1).
module cas_sdram_arb #(
    parameter int unsigned ADDR_W = 25,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    cas_sdram_arb_if.slave bus
);
    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic              pend0_q,      pend0_d;
    logic              pend1_q,      pend1_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q,        gnt_d;
    logic              kill0_q,      kill0_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic [ADDR_W-1:0] addr0_q,      addr0_d;
    logic [ADDR_W-1:0] addr1_q,      addr1_d;
    logic [ADDR_W-1:0] sdram_addr_q, sdram_addr_d;
    logic              sdram_rd_q,   sdram_rd_d;
    logic              ack0_q,       ack0_d;
    logic              ack1_q,       ack1_d;
    logic [DATA_W-1:0] data0_q,      data0_d;
    logic [DATA_W-1:0] data1_q,      data1_d;
    logic              busy_q,       busy_d;

    logic inflight0_c, inflight1_c;
    logic cand0_c, grant_c, sel_c;
    logic take0_c, take1_c, acc0_c, acc1_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pend0_q      <= 1'b0;
            pend1_q      <= 1'b0;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            kill0_q      <= 1'b0;
            cnt_q        <= '0;
            addr0_q      <= '0;
            addr1_q      <= '0;
            sdram_addr_q <= '0;
            sdram_rd_q   <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            data0_q      <= '0;
            data1_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend0_q      <= pend0_d;
            pend1_q      <= pend1_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            kill0_q      <= kill0_d;
            cnt_q        <= cnt_d;
            addr0_q      <= addr0_d;
            addr1_q      <= addr1_d;
            sdram_addr_q <= sdram_addr_d;
            sdram_rd_q   <= sdram_rd_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pend0_d      = pend0_q;
        pend1_d      = pend1_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        kill0_d      = kill0_q;
        cnt_d        = cnt_q;
        addr0_d      = addr0_q;
        addr1_d      = addr1_q;
        sdram_addr_d = sdram_addr_q;
        sdram_rd_d   = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        data0_d      = data0_q;
        data1_d      = data1_q;

        inflight0_c = (state_q != S_IDLE) && (gnt_q == 1'b0);
        inflight1_c = (state_q != S_IDLE) && (gnt_q == 1'b1);

        // A flush in the grant cycle withdraws port 0 from this arbitration round
        cand0_c = pend0_q && !bus.flush0;
        grant_c = (state_q == S_IDLE) && (cand0_c || pend1_q);
        sel_c   = (cand0_c && pend1_q) ? ~last_grant_q : pend1_q;
        take0_c = grant_c && !sel_c;
        take1_c = grant_c && sel_c;

        // A grant or flush frees the pending slot in the same cycle
        acc0_c = bus.req0 && !inflight0_c && (!pend0_q || take0_c || bus.flush0);
        acc1_c = bus.req1 && !inflight1_c && (!pend1_q || take1_c);

        if (bus.flush0 || take0_c) pend0_d = 1'b0;
        if (take1_c)               pend1_d = 1'b0;
        if (acc0_c) begin
            pend0_d = 1'b1;
            addr0_d = bus.addr0;
        end
        if (acc1_c) begin
            pend1_d = 1'b1;
            addr1_d = bus.addr1;
        end

        if (bus.flush0 && inflight0_c) kill0_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (grant_c) begin
                    gnt_d        = sel_c;
                    last_grant_d = sel_c;
                    sdram_addr_d = sel_c ? addr1_q : addr0_q;
                    sdram_rd_d   = 1'b1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(RD_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (gnt_q) begin
                        data1_d = bus.sdram_data;
                        ack1_d  = 1'b1;
                    end else if (!(kill0_q || bus.flush0)) begin
                        data0_d = bus.sdram_data;
                        ack0_d  = 1'b1;
                    end
                    kill0_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.ack0       = ack0_q;
    assign bus.data0      = data0_q;
    assign bus.ack1       = ack1_q;
    assign bus.data1      = data1_q;
    assign bus.sdram_addr = sdram_addr_q;
    assign bus.sdram_rd   = sdram_rd_q;
    assign bus.busy       = busy_q;

endmodule
